// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: bus width, FSM encoding,
// and the byte-lane shift / word-crossing helpers used by the write merge.
package dmem_responder_pkg;

  localparam int BUS_64 = 64;

  typedef enum logic [2:0] {
    DMEM_ST_IDLE    = 3'd0,
    DMEM_ST_RD_WAIT = 3'd1,
    DMEM_ST_RD_RESP = 3'd2,
    DMEM_ST_WR_RD   = 3'd3,
    DMEM_ST_WR_MRG  = 3'd4
  } dmem_state_t;

  // Move an LSB-aligned value up to its byte lane; bits pushed past bit 63 are lost.
  function automatic logic [BUS_64-1:0] byte_shift_up(input logic [BUS_64-1:0] v,
                                                      input logic [2:0]        off);
    return v << {off, 3'b000};
  endfunction

  // True when a shifted mask would spill into the next word.
  function automatic logic write_crosses(input logic [BUS_64-1:0] mask,
                                         input logic [2:0]        off);
    logic [6:0] sh;
    sh = 7'd64 - {1'b0, off, 3'b000};
    return (off != 3'd0) && ((mask >> sh) != '0);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-to-data-memory request/response bundle; the core drives the master side.
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic              mem_ren;
  logic [BUS_64-1:0] mem_raddr;
  logic              mem_wen;
  logic [BUS_64-1:0] mem_waddr;
  logic [BUS_64-1:0] mem_wdata;
  logic [BUS_64-1:0] mem_wmask;
  logic              mem_ready;
  logic [BUS_64-1:0] mem_rdata;
  logic              mem_rvalid;
  logic              mem_wdone;
  logic              mem_err;

  modport master (
    output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask,
    input  mem_ready, mem_rdata, mem_rvalid, mem_wdone, mem_err
  );

  modport slave (
    input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask,
    output mem_ready, mem_rdata, mem_rvalid, mem_wdone, mem_err
  );

endinterface

// File: rtl/dmem_sram.sv
// Single-port DEPTH x 64 RAM with one-cycle registered read and full-word write.
module dmem_sram #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          re,
  input  logic          we,
  input  logic [63:0]   wdata,
  output logic [63:0]   q
);

  logic [63:0] mem_array [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_array[addr] <= wdata;
    end
    if (re) begin
      q <= mem_array[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one read or masked read-modify-write at a time over a local RAM.
// Optional macro DMEM_MISALIGN_CHK_EN rejects word-crossing writes with an mem_err pulse.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH      = 4096,
  parameter int AW         = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave mem
);

  dmem_state_t       state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [AW-1:0]     addr_reg, addr_next;
  logic [2:0]        off_reg, off_next;
  logic [BUS_64-1:0] wdata_reg, wdata_next;
  logic [BUS_64-1:0] wmask_reg, wmask_next;
  logic [BUS_64-1:0] rdata_reg, rdata_next;

  logic [BUS_64-1:0] ram_q;
  logic              ram_re;
  logic              ram_we;
  logic [BUS_64-1:0] shift_m;
  logic [BUS_64-1:0] shift_d;
  logic [BUS_64-1:0] merged_word;
  logic [BUS_64-1:0] rd_shifted;
  logic              reject;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{mem.mem_raddr[BUS_64-1:AW+3], mem.mem_waddr[BUS_64-1:AW+3]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= DMEM_ST_IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      off_reg   <= '0;
      wdata_reg <= '0;
      wmask_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
      off_reg   <= off_next;
      wdata_reg <= wdata_next;
      wmask_reg <= wmask_next;
      rdata_reg <= rdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    off_next   = off_reg;
    wdata_next = wdata_reg;
    wmask_next = wmask_reg;
    rdata_next = rdata_reg;
    case (state_reg)
      DMEM_ST_IDLE: begin
        // Write wins when both requests arrive together; the read is dropped.
        if (mem.mem_wen) begin
          state_next = DMEM_ST_WR_RD;
          addr_next  = mem.mem_waddr[AW+2:3];
          off_next   = mem.mem_waddr[2:0];
          wdata_next = mem.mem_wdata;
          wmask_next = mem.mem_wmask;
        end else if (mem.mem_ren) begin
          state_next = DMEM_ST_RD_WAIT;
          cnt_next   = 4'(RD_LATENCY - 1);
          addr_next  = mem.mem_raddr[AW+2:3];
          off_next   = mem.mem_raddr[2:0];
        end
      end
      DMEM_ST_RD_WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = DMEM_ST_RD_RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DMEM_ST_RD_RESP: begin
        rdata_next = rd_shifted;
        state_next = DMEM_ST_IDLE;
      end
      DMEM_ST_WR_RD:  state_next = DMEM_ST_WR_MRG;
      DMEM_ST_WR_MRG: state_next = DMEM_ST_IDLE;
      default:        state_next = DMEM_ST_IDLE;
    endcase
  end

  assign shift_m     = byte_shift_up(wmask_reg, off_reg);
  assign shift_d     = byte_shift_up(wdata_reg, off_reg);
  assign merged_word = (ram_q & ~shift_m) | (shift_d & shift_m);
  assign rd_shifted  = ram_q >> {off_reg, 3'b000};

`ifdef DMEM_MISALIGN_CHK_EN
  assign reject      = write_crosses(wmask_reg, off_reg);
  assign mem.mem_err = (state_reg == DMEM_ST_WR_MRG) && reject;
`else
  assign reject      = 1'b0;
  assign mem.mem_err = 1'b0;
`endif

  assign ram_re = ((state_reg == DMEM_ST_RD_WAIT) && (cnt_reg == 4'd0)) ||
                  (state_reg == DMEM_ST_WR_RD);
  assign ram_we = (state_reg == DMEM_ST_WR_MRG) && !reject;

  // Read data is visible in the RD_RESP cycle itself and then held from rdata_reg.
  assign mem.mem_ready  = (state_reg == DMEM_ST_IDLE);
  assign mem.mem_rvalid = (state_reg == DMEM_ST_RD_RESP);
  assign mem.mem_rdata  = (state_reg == DMEM_ST_RD_RESP) ? rd_shifted : rdata_reg;
  assign mem.mem_wdone  = ram_we;

  dmem_sram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_sram (
    .clk  (clk),
    .addr (addr_reg),
    .re   (ram_re),
    .we   (ram_we),
    .wdata(merged_word),
    .q    (ram_q)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: random and directed requests against a bit-level memory model.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int RD_LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  dmem_responder_if bus();

  dmem_responder #(
    .DEPTH     (4096),
    .AW        (12),
    .RD_LATENCY(RD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem(bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec  = 0;
  int n_miss = 0;
  int n_txn  = 0;

  typedef struct {
    int          kind;   // 0 read data, 1 write done, 2 write rejected
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] model_mem[int];
  logic [63:0] last_rdata = '0;

  task automatic checkv(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model works bit by bit over byte positions rather than with shifts of whole words.
  function automatic logic [63:0] model_read(input logic [63:0] w, input logic [2:0] off);
    logic [63:0] r;
    int o;
    r = '0;
    o = 8 * int'(off);
    for (int i = 0; i < 64; i++) if (i + o < 64) r[i] = w[i + o];
    return r;
  endfunction

  function automatic logic [63:0] model_merge(input logic [63:0] w, input logic [63:0] d,
                                              input logic [63:0] m, input logic [2:0] off);
    logic [63:0] r;
    int o;
    r = w;
    o = 8 * int'(off);
    for (int i = 0; i < 64; i++) if (m[i] && (i + o < 64)) r[i + o] = d[i];
    return r;
  endfunction

  function automatic bit model_crosses(input logic [63:0] m, input logic [2:0] off);
    int o;
    o = 8 * int'(off);
    for (int i = 0; i < 64; i++) if (m[i] && (i + o >= 64)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] mk_addr(input int sel, input int off);
    logic [63:0] a;
    a       = {$urandom(), $urandom()};
    a[14:3] = 12'(sel);
    a[2:0]  = 3'(off);
    return a;
  endfunction

  function automatic logic [63:0] rand_mask();
    case ($urandom_range(0, 5))
      0:       return 64'hFF;
      1:       return 64'hFFFF;
      2:       return 64'hFFFF_FFFF;
      3:       return '1;
      4:       return {$urandom(), $urandom()};
      default: return '0;
    endcase
  endfunction

  // Monitor: every response pulse must match the head of the scoreboard queue.
  int   mon_kind;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst && (bus.mem_rvalid || bus.mem_wdone || bus.mem_err)) begin
      mon_kind = bus.mem_rvalid ? 0 : (bus.mem_wdone ? 1 : 2);
      checkv("pulse_onehot", 64'(int'(bus.mem_rvalid) + int'(bus.mem_wdone) + int'(bus.mem_err)), 64'd1);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_pulse: got response kind %0d at cycle %0d, required none", mon_kind, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        checkv("resp_kind", 64'(mon_kind), 64'(mon_e.kind));
        checkv("resp_cycle", 64'(cyc), 64'(mon_e.due));
        if (mon_e.kind == 0) checkv("rdata", bus.mem_rdata, mon_e.data);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge where mem_ready is back high.
  task automatic do_req(input bit wen, input bit ren, input logic [63:0] waddr,
                        input logic [63:0] wdata, input logic [63:0] wmask,
                        input logic [63:0] raddr, input bit junk);
    int   t0;
    int   guard;
    int   lat;
    int   idx;
    bit   rej;
    exp_t e;
    guard = 0;
    while (!bus.mem_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkv("ready_before_req", 64'(bus.mem_ready), 64'd1);
    checkv("rdata_hold", bus.mem_rdata, last_rdata);
    bus.mem_wen   = wen;
    bus.mem_ren   = ren;
    bus.mem_waddr = waddr;
    bus.mem_wdata = wdata;
    bus.mem_wmask = wmask;
    bus.mem_raddr = raddr;
    t0 = cyc;
    n_txn++;
    if (wen) begin
      idx = int'(waddr[14:3]);
`ifdef DMEM_MISALIGN_CHK_EN
      rej = model_crosses(wmask, waddr[2:0]);
`else
      rej = 1'b0;
`endif
      e.kind = rej ? 2 : 1;
      e.data = '0;
      e.due  = t0 + 2;
      if (!rej) model_mem[idx] = model_merge(model_mem[idx], wdata, wmask, waddr[2:0]);
      lat = 3;
      $display("txn %0d cyc %0d WRITE addr=%h data=%h mask=%h%s", n_txn, t0, waddr, wdata, wmask,
               ren ? " (read dropped)" : "");
    end else begin
      idx    = int'(raddr[14:3]);
      e.kind = 0;
      e.data = model_read(model_mem[idx], raddr[2:0]);
      e.due  = t0 + 1 + RD_LAT;
      last_rdata = e.data;
      lat    = 2 + RD_LAT;
      $display("txn %0d cyc %0d READ  addr=%h expect=%h", n_txn, t0, raddr, e.data);
    end
    exp_q.push_back(e);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
      if (!bus.mem_ready && junk) begin
        bus.mem_ren   = 1'($urandom_range(0, 1));
        bus.mem_wen   = 1'($urandom_range(0, 1));
        bus.mem_raddr = {$urandom(), $urandom()};
        bus.mem_waddr = {$urandom(), $urandom()};
        bus.mem_wdata = {$urandom(), $urandom()};
        bus.mem_wmask = '1;
      end else begin
        bus.mem_ren = 1'b0;
        bus.mem_wen = 1'b0;
      end
    end while (!bus.mem_ready && guard < 50);
    bus.mem_ren = 1'b0;
    bus.mem_wen = 1'b0;
    checkv("ready_return_cycle", 64'(cyc), 64'(t0 + lat));
  endtask

  initial begin
    logic [63:0] a;
    bus.mem_ren   = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_raddr = '0;
    bus.mem_waddr = '0;
    bus.mem_wdata = '0;
    bus.mem_wmask = '0;

    repeat (3) @(negedge clk);
    checkv("reset_ready", 64'(bus.mem_ready), 64'd1);
    checkv("reset_rvalid", 64'(bus.mem_rvalid), 64'd0);
    checkv("reset_wdone", 64'(bus.mem_wdone), 64'd0);
    checkv("reset_err", 64'(bus.mem_err), 64'd0);
    checkv("reset_rdata", bus.mem_rdata, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Give every word the bench may read a known value.
    for (int s = 0; s < 16; s++) begin
      model_mem[s] = '0;
      do_req(1'b1, 1'b0, mk_addr(s, 0), {$urandom(), $urandom()}, '1, '0, 1'b0);
    end

    // Directed scenarios: SD/LD, SB merge, offset read, crossing SW, busy and simultaneous requests.
    do_req(1'b1, 1'b0, 64'h8000_0010, 64'h1122_3344_5566_7788, '1, '0, 1'b0);
    do_req(1'b0, 1'b1, '0, '0, '0, 64'h8000_0010, 1'b0);
    do_req(1'b1, 1'b0, 64'h8000_0013, 64'hAB, 64'hFF, '0, 1'b0);
    do_req(1'b0, 1'b1, '0, '0, '0, 64'h8000_0010, 1'b0);
    do_req(1'b0, 1'b1, '0, '0, '0, 64'h8000_0013, 1'b0);
    do_req(1'b1, 1'b0, 64'h8000_0016, 64'hDEAD_BEEF_CAFE_BABE, 64'hFFFF_FFFF, '0, 1'b1);
    do_req(1'b0, 1'b1, '0, '0, '0, 64'h8000_0010, 1'b0);
    do_req(1'b1, 1'b1, mk_addr(5, 1), {$urandom(), $urandom()}, rand_mask(), mk_addr(9, 0), 1'b0);
    do_req(1'b0, 1'b1, '0, '0, '0, mk_addr(5, 0), 1'b0);
    do_req(1'b1, 1'b0, mk_addr(7, 3), {$urandom(), $urandom()}, '0, '0, 1'b0);
    do_req(1'b0, 1'b1, '0, '0, '0, mk_addr(7, 0), 1'b0);

    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 3))
        0, 3: do_req(1'b0, 1'b1, '0, '0, '0, mk_addr($urandom_range(0, 15), $urandom_range(0, 7)),
                     1'($urandom_range(0, 1)));
        1:    do_req(1'b1, 1'b0, mk_addr($urandom_range(0, 15), $urandom_range(0, 7)),
                     {$urandom(), $urandom()}, rand_mask(), '0, 1'($urandom_range(0, 1)));
        default: do_req(1'b1, 1'b1, mk_addr($urandom_range(0, 15), $urandom_range(0, 7)),
                        {$urandom(), $urandom()}, rand_mask(),
                        mk_addr($urandom_range(0, 15), $urandom_range(0, 7)), 1'b0);
      endcase
    end

    // Reset in the middle of a read wait: outputs drop at once, no response later.
    bus.mem_ren   = 1'b1;
    bus.mem_raddr = mk_addr(3, 2);
    @(negedge clk);
    bus.mem_ren = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkv("abort_rd_ready", 64'(bus.mem_ready), 64'd1);
    checkv("abort_rd_rvalid", 64'(bus.mem_rvalid), 64'd0);
    checkv("abort_rd_rdata", bus.mem_rdata, 64'd0);
    last_rdata = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (RD_LAT + 3) @(negedge clk);
    checkv("abort_rd_ready_after", 64'(bus.mem_ready), 64'd1);

    // Reset before the merge edge of a write: the RAM word must be untouched.
    a = mk_addr(4, 0);
    bus.mem_wen   = 1'b1;
    bus.mem_waddr = a;
    bus.mem_wdata = ~model_mem[4];
    bus.mem_wmask = '1;
    @(negedge clk);
    bus.mem_wen = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkv("abort_wr_ready", 64'(bus.mem_ready), 64'd1);
    checkv("abort_wr_wdone", 64'(bus.mem_wdone), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_req(1'b0, 1'b1, '0, '0, '0, a, 1'b0);

    repeat (RD_LAT + 4) @(negedge clk);
    checkv("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
